// File: rtl/button_event_arbiter_if.sv
// ---------------------------------------------------------------------------
// button_event_arbiter_if
// Single-event valid/ready port between the button event arbiter (master)
// and the control FSM that consumes button events (slave).
//   evt_valid : event available (master -> slave)
//   evt_ready : consumer accepts the event this cycle (slave -> master)
//   evt_btn   : index of the button that produced the event
//   evt_type  : 2'b01 SHORT, 2'b10 LONG, 2'b11 REPEAT
// ---------------------------------------------------------------------------
interface button_event_arbiter_if #(
    parameter int NUM_BTN = 4
);
    localparam int BW = $clog2(NUM_BTN);

    logic          evt_valid;
    logic          evt_ready;
    logic [BW-1:0] evt_btn;
    logic [1:0]    evt_type;

    modport master (
        output evt_valid,
        output evt_btn,
        output evt_type,
        input  evt_ready
    );

    modport slave (
        input  evt_valid,
        input  evt_btn,
        input  evt_type,
        output evt_ready
    );
endinterface

// File: rtl/button_event_arbiter.sv
// ---------------------------------------------------------------------------
// button_event_arbiter
// Turns debounced press/release pulses from NUM_BTN active-low buttons into
// SHORT / LONG / REPEAT events, queues one pending event per button and
// round-robins them onto a single valid/ready event port.
// Ports:
//   clk         : system clock
//   rst_n       : asynchronous active-low reset
//   btn_press   : one-cycle press pulses, one bit per button
//   btn_release : one-cycle release pulses, one bit per button
//   evt         : event port (valid/ready, button index, event type)
//   drop_flag   : sticky per-button flag, a pending event was overwritten
//   clr_drop    : clears every drop_flag bit on the next edge
// ---------------------------------------------------------------------------
module button_event_arbiter #(
    parameter int NUM_BTN       = 4,
    parameter int N             = 32,
    parameter int LONG_CYCLES   = 50_000_000,
    parameter int REPEAT_CYCLES = 10_000_000
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_BTN-1:0]            btn_press,
    input  logic [NUM_BTN-1:0]            btn_release,
    button_event_arbiter_if.master        evt,
    output logic [NUM_BTN-1:0]            drop_flag,
    input  logic                          clr_drop
);
    localparam int BW = $clog2(NUM_BTN);

    localparam logic [1:0] EVT_NONE   = 2'b00;
    localparam logic [1:0] EVT_SHORT  = 2'b01;
    localparam logic [1:0] EVT_LONG   = 2'b10;
    localparam logic [1:0] EVT_REPEAT = 2'b11;

    localparam logic [N-1:0] LONG_LAST   = N'(LONG_CYCLES - 1);
    localparam logic [N-1:0] REPEAT_LAST = N'(REPEAT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PRESSED = 2'd1,
        S_HELD    = 2'd2
    } btn_state_e;

    logic [NUM_BTN-1:0] pending;
    logic [1:0]         slot_type [NUM_BTN];
    logic [NUM_BTN-1:0] grant;

    // ------------------------------------------------------------------
    // Per-button classifier FSM and pending slot
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_btn
        btn_state_e  state_q, state_d;
        logic [N-1:0] timer_q, timer_d;
        logic        slot_valid_q, slot_valid_d;
        logic [1:0]  slot_type_q, slot_type_d;
        logic        drop_q, drop_d;
        logic [1:0]  emit;
        logic        pr, rl;
        logic        drop_set;

        always_comb begin
            // A press and release in the same cycle cancel each other out.
            pr       = btn_press[gi] & ~btn_release[gi];
            rl       = btn_release[gi] & ~btn_press[gi];
            state_d  = state_q;
            timer_d  = timer_q;
            emit     = EVT_NONE;
            case (state_q)
                S_IDLE: begin
                    if (pr) begin
                        state_d = S_PRESSED;
                        timer_d = '0;
                    end
                end
                S_PRESSED: begin
                    // Release is checked first so it beats the LONG expiry.
                    if (rl) begin
                        emit    = EVT_SHORT;
                        state_d = S_IDLE;
                    end else if (timer_q == LONG_LAST) begin
                        emit    = EVT_LONG;
                        state_d = S_HELD;
                        timer_d = '0;
                    end else begin
                        timer_d = timer_q + N'(1);
                    end
                end
                S_HELD: begin
                    if (rl) begin
                        state_d = S_IDLE;
                    end else if (timer_q == REPEAT_LAST) begin
                        emit    = EVT_REPEAT;
                        timer_d = '0;
                    end else begin
                        timer_d = timer_q + N'(1);
                    end
                end
                default: state_d = S_IDLE;
            endcase

            // A new event always lands in the slot; it only counts as a
            // drop when the old one is not leaving through the arbiter.
            slot_valid_d = slot_valid_q;
            slot_type_d  = slot_type_q;
            drop_set     = 1'b0;
            if (emit != EVT_NONE) begin
                drop_set     = slot_valid_q & ~grant[gi];
                slot_valid_d = 1'b1;
                slot_type_d  = emit;
            end else if (grant[gi]) begin
                slot_valid_d = 1'b0;
            end
            drop_d = drop_set | (drop_q & ~clr_drop);
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_q      <= S_IDLE;
                timer_q      <= '0;
                slot_valid_q <= 1'b0;
                slot_type_q  <= EVT_NONE;
                drop_q       <= 1'b0;
            end else begin
                state_q      <= state_d;
                timer_q      <= timer_d;
                slot_valid_q <= slot_valid_d;
                slot_type_q  <= slot_type_d;
                drop_q       <= drop_d;
            end
        end

        assign pending[gi]   = slot_valid_q;
        assign slot_type[gi] = slot_type_q;
        assign drop_flag[gi] = drop_q;
    end

    // ------------------------------------------------------------------
    // Round-robin arbiter and output register
    // ------------------------------------------------------------------
    logic          evt_valid_q, evt_valid_d;
    logic [BW-1:0] evt_btn_q, evt_btn_d;
    logic [1:0]    evt_type_q, evt_type_d;
    logic [BW-1:0] rr_ptr_q, rr_ptr_d;
    logic          load_en;
    logic          gnt_found;
    logic [BW-1:0] gnt_idx;

    always_comb begin
        logic [BW:0] idx;
        load_en   = ~evt_valid_q | evt.evt_ready;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        grant     = '0;
        idx       = '0;
        // Scan from the pointer upward, wrapping past the last button.
        for (int off = 0; off < NUM_BTN; off++) begin
            idx = {1'b0, rr_ptr_q} + (BW+1)'(off);
            if (idx >= (BW+1)'(NUM_BTN)) begin
                idx = idx - (BW+1)'(NUM_BTN);
            end
            if (!gnt_found && pending[idx[BW-1:0]]) begin
                gnt_found = 1'b1;
                gnt_idx   = idx[BW-1:0];
            end
        end
        if (load_en && gnt_found) begin
            grant[gnt_idx] = 1'b1;
        end

        evt_valid_d = evt_valid_q;
        evt_btn_d   = evt_btn_q;
        evt_type_d  = evt_type_q;
        rr_ptr_d    = rr_ptr_q;
        if (load_en) begin
            evt_valid_d = gnt_found;
            if (gnt_found) begin
                evt_btn_d  = gnt_idx;
                evt_type_d = slot_type[gnt_idx];
                rr_ptr_d   = (gnt_idx == BW'(NUM_BTN - 1)) ? '0 : gnt_idx + BW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            evt_valid_q <= 1'b0;
            evt_btn_q   <= '0;
            evt_type_q  <= EVT_NONE;
            rr_ptr_q    <= '0;
        end else begin
            evt_valid_q <= evt_valid_d;
            evt_btn_q   <= evt_btn_d;
            evt_type_q  <= evt_type_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign evt.evt_valid = evt_valid_q;
    assign evt.evt_btn   = evt_btn_q;
    assign evt.evt_type  = evt_type_q;
endmodule
